reg_file_mw: RTL and testbench

- Parametrised multi-register, multi-mode storage block for the CPU datapath.
- Generalises the single load/hold register into DEPTH registers of WIDTH bits.
- One write port supports load, clear, increment and decrement. Two asynchronous read ports have optional write-through bypass.
- Tracks which registers have been written since reset. Used as the general-purpose register bank and as a counter/pointer bank.

---
 rtl/reg_file_pkg.sv | 9 +
 rtl/reg_next_val.sv | 19 +
 rtl/reg_file_mw.sv | 59 +++++
 tb/tb_reg_file_mw.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared write-mode encoding for the multi-mode register file
package reg_file_pkg;
  typedef enum logic [1:0] {
    WM_LOAD  = 2'b00,
    WM_CLEAR = 2'b01,
    WM_INC   = 2'b10,
    WM_DEC   = 2'b11
  } wmode_t;
endpackage

// File: rtl/reg_next_val.sv
// reg_next_val: next-value and wrap calculator shared by the write and bypass paths
module reg_next_val
  import reg_file_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  wmode_t           mode,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] next,
  output logic             wrap
);
  always_comb begin
    next = mode == WM_LOAD  ? wdata :
           mode == WM_CLEAR ? '0 :
           mode == WM_INC   ? cur + WIDTH'(1) : cur - WIDTH'(1);
    wrap = (mode == WM_INC && &cur) || (mode == WM_DEC && ~|cur);
  end
endmodule

// File: rtl/reg_file_mw.sv
// reg_file_mw: DEPTH x WIDTH register bank, one multi-mode write port, two bypassed read ports
module reg_file_mw
  import reg_file_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 8,
  parameter  int ZERO_REG = 0,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        wmode,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic [DEPTH-1:0]  written,
  output logic              wovf
);
  localparam logic [ADDR_W:0] DL = (ADDR_W + 1)'(DEPTH);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] nxt;
  logic             wrap;
  logic             wen;
  assign wen = we && {1'b0, waddr} < DL && !(ZERO_REG != 0 && waddr == '0);
  reg_next_val #(.WIDTH(WIDTH)) u_nv (
    .cur  (regs[waddr]),
    .mode (wmode_t'(wmode)),
    .wdata(wdata),
    .next (nxt),
    .wrap (wrap)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      written <= '0;
      wovf    <= 1'b0;
    end else begin
      wovf <= wen && wrap;
      if (wen) begin
        regs[waddr]    <= nxt;
        written[waddr] <= 1'b1;
      end
    end
  end
  // out-of-range and hardwired-zero addresses win over bypass
  function automatic logic [WIDTH-1:0] rd(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= DL || (ZERO_REG != 0 && a == '0)) ? '0 :
           (BYPASS != 0 && wen && a == waddr) ? nxt : regs[a];
  endfunction
  always_comb begin
    rdata_a = rd(raddr_a);
    rdata_b = rd(raddr_b);
  end
endmodule

// File: tb/tb_reg_file_mw.sv
// tb_reg_file_mw: table vectors, a reset corner sequence and a random model check on two configurations
module tb_reg_file_mw;
  import reg_file_pkg::*;
  logic       clk = 1'b0;
  logic       rst, we;
  logic [1:0] wmode;
  logic [2:0] waddr, raddr_a, raddr_b;
  logic [7:0] wdata;
  logic [7:0] ra0, rb0, ra1, rb1, wr0;
  logic [5:0] wr1;
  logic       ov0, ov1;
  int passed = 0, total = 0;
  reg_file_mw u0 (
    .clk(clk), .rst(rst), .we(we), .wmode(wmode), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(ra0), .raddr_b(raddr_b), .rdata_b(rb0),
    .written(wr0), .wovf(ov0)
  );
  reg_file_mw #(.DEPTH(6), .ZERO_REG(1), .BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .we(we), .wmode(wmode), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(ra1), .raddr_b(raddr_b), .rdata_b(rb1),
    .written(wr1), .wovf(ov1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", n, got, exp);
  endtask
  typedef struct {
    int we, m, wa, wd, a, b, ea0, eb0, ea1, eb1, ew0, ew1, ev0, ev1;
  } tv_t;
  tv_t tab [20];
  int dep [2] = '{8, 6};
  int zr  [2] = '{0, 1};
  int byp [2] = '{1, 0};
  int mem [2][8];
  int wrm [2];
  int ovm [2];
  function automatic int nv(int cur, int m, int wd);
    return m == 0 ? wd : m == 1 ? 0 : m == 2 ? (cur + 1) % 256 : (cur + 255) % 256;
  endfunction
  function automatic bit legal(int c, int a);
    return a < dep[c] && !(zr[c] == 1 && a == 0);
  endfunction
  function automatic int mrd(int c, int a);
    if (a >= dep[c] || (zr[c] == 1 && a == 0)) return 0;
    if (byp[c] == 1 && we && legal(c, int'(waddr)) && a == int'(waddr))
      return nv(mem[c][waddr], int'(wmode), int'(wdata));
    return mem[c][a];
  endfunction
  initial begin
    tab = '{
      '{1, WM_LOAD,  3, 'hA5, 3, 4, 'hA5, 0,    0,    0,    'h08, 'h08, 0, 0},
      '{0, WM_LOAD,  0, 0,    3, 0, 'hA5, 0,    'hA5, 0,    'h08, 'h08, 0, 0},
      '{1, WM_LOAD,  5, 'hFF, 5, 5, 'hFF, 'hFF, 0,    0,    'h28, 'h28, 0, 0},
      '{1, WM_INC,   5, 0,    5, 3, 0,    'hA5, 'hFF, 'hA5, 'h28, 'h28, 1, 1},
      '{1, WM_DEC,   5, 0,    5, 5, 'hFF, 'hFF, 0,    0,    'h28, 'h28, 1, 1},
      '{1, WM_INC,   5, 0,    5, 2, 0,    0,    'hFF, 0,    'h28, 'h28, 1, 1},
      '{0, WM_LOAD,  0, 0,    5, 5, 0,    0,    0,    0,    'h28, 'h28, 0, 0},
      '{1, WM_LOAD,  2, 'h10, 2, 2, 'h10, 'h10, 0,    0,    'h2C, 'h2C, 0, 0},
      '{1, WM_INC,   2, 0,    2, 2, 'h11, 'h11, 'h10, 'h10, 'h2C, 'h2C, 0, 0},
      '{0, WM_LOAD,  0, 0,    2, 2, 'h11, 'h11, 'h11, 'h11, 'h2C, 'h2C, 0, 0},
      '{1, WM_LOAD,  0, 'h3C, 0, 0, 'h3C, 'h3C, 0,    0,    'h2D, 'h2C, 0, 0},
      '{0, WM_LOAD,  0, 0,    0, 1, 'h3C, 0,    0,    0,    'h2D, 'h2C, 0, 0},
      '{1, WM_LOAD,  7, 'h55, 7, 5, 'h55, 0,    0,    0,    'hAD, 'h2C, 0, 0},
      '{0, WM_LOAD,  0, 0,    7, 3, 'h55, 'hA5, 0,    'hA5, 'hAD, 'h2C, 0, 0},
      '{1, WM_LOAD,  6, 'h66, 6, 6, 'h66, 'h66, 0,    0,    'hED, 'h2C, 0, 0},
      '{1, WM_CLEAR, 3, 'hEE, 3, 4, 0,    0,    'hA5, 0,    'hED, 'h2C, 0, 0},
      '{1, WM_CLEAR, 4, 0,    4, 3, 0,    0,    0,    0,    'hFD, 'h3C, 0, 0},
      '{1, WM_DEC,   1, 0,    1, 1, 'hFF, 'hFF, 0,    0,    'hFF, 'h3E, 1, 1},
      '{0, WM_LOAD,  0, 0,    1, 5, 'hFF, 0,    'hFF, 0,    'hFF, 'h3E, 0, 0},
      '{1, WM_INC,   2, 0,    2, 0, 'h12, 'h3C, 'h11, 0,    'hFF, 'h3E, 0, 0}
    };
    rst = 1'b1; we = 1'b0; wmode = 2'b00; waddr = '0; wdata = '0; raddr_a = 3'd3; raddr_b = 3'd7;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_written0", 32'(wr0), 0);
    chk("rst_written1", 32'(wr1), 0);
    chk("rst_wovf0", 32'(ov0), 0);
    chk("rst_wovf1", 32'(ov1), 0);
    chk("rst_rd0", 32'(ra0), 0);
    chk("rst_rd1", 32'(ra1), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      we = tab[i].we != 0; wmode = 2'(tab[i].m); waddr = 3'(tab[i].wa); wdata = 8'(tab[i].wd);
      raddr_a = 3'(tab[i].a); raddr_b = 3'(tab[i].b);
      #1;
      chk($sformatf("v%0d_rda0", i), 32'(ra0), tab[i].ea0);
      chk($sformatf("v%0d_rdb0", i), 32'(rb0), tab[i].eb0);
      chk($sformatf("v%0d_rda1", i), 32'(ra1), tab[i].ea1);
      chk($sformatf("v%0d_rdb1", i), 32'(rb1), tab[i].eb1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_written0", i), 32'(wr0), tab[i].ew0);
      chk($sformatf("v%0d_written1", i), 32'(wr1), tab[i].ew1);
      chk($sformatf("v%0d_wovf0", i), 32'(ov0), tab[i].ev0);
      chk($sformatf("v%0d_wovf1", i), 32'(ov1), tab[i].ev1);
    end
    // reset arriving together with a write, while wovf is high
    @(negedge clk) begin we = 1'b1; wmode = WM_LOAD; waddr = 3'd5; wdata = 8'hFF; end
    @(negedge clk) wmode = WM_INC;
    @(negedge clk) begin rst = 1'b1; wmode = WM_LOAD; waddr = 3'd4; wdata = 8'h99; end
    #1;
    chk("pre_rst_wovf0", 32'(ov0), 1);
    chk("pre_rst_wovf1", 32'(ov1), 1);
    @(posedge clk); #1;
    chk("mid_rst_written0", 32'(wr0), 0);
    chk("mid_rst_written1", 32'(wr1), 0);
    chk("mid_rst_wovf0", 32'(ov0), 0);
    chk("mid_rst_wovf1", 32'(ov1), 0);
    @(negedge clk) begin rst = 1'b0; we = 1'b0; end
    for (int a = 0; a < 8; a++) begin
      raddr_a = 3'(a); raddr_b = 3'(7 - a);
      #1;
      chk($sformatf("mid_rst_rd0_%0d", a), 32'(ra0), 0);
      chk($sformatf("mid_rst_rd1_%0d", a), 32'(rb1), 0);
    end
    for (int c = 0; c < 2; c++) begin
      wrm[c] = 0; ovm[c] = 0;
      for (int a = 0; a < 8; a++) mem[c][a] = 0;
    end
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst = $urandom_range(0, 39) == 0;
      we = $urandom_range(0, 3) != 0;
      wmode = 2'($urandom);
      waddr = 3'($urandom);
      case ($urandom_range(0, 2))
        0: wdata = 8'h00;
        1: wdata = 8'hFF;
        default: wdata = 8'($urandom);
      endcase
      raddr_a = $urandom_range(0, 2) == 0 ? waddr : 3'($urandom);
      raddr_b = $urandom_range(0, 2) == 0 ? raddr_a : 3'($urandom);
      #1;
      if (!rst) begin
        chk($sformatf("r%0d_rda0", n), 32'(ra0), mrd(0, int'(raddr_a)));
        chk($sformatf("r%0d_rdb0", n), 32'(rb0), mrd(0, int'(raddr_b)));
        chk($sformatf("r%0d_rda1", n), 32'(ra1), mrd(1, int'(raddr_a)));
        chk($sformatf("r%0d_rdb1", n), 32'(rb1), mrd(1, int'(raddr_b)));
      end
      for (int c = 0; c < 2; c++) begin
        if (rst) begin
          wrm[c] = 0; ovm[c] = 0;
          for (int a = 0; a < 8; a++) mem[c][a] = 0;
        end else begin
          ovm[c] = 0;
          if (we && legal(c, int'(waddr))) begin
            ovm[c] = int'((wmode == 2'd2 && mem[c][waddr] == 255) || (wmode == 2'd3 && mem[c][waddr] == 0));
            mem[c][waddr] = nv(mem[c][waddr], int'(wmode), int'(wdata));
            wrm[c] = wrm[c] | (1 << waddr);
          end
        end
      end
      @(posedge clk); #1;
      chk($sformatf("r%0d_written0", n), 32'(wr0), wrm[0]);
      chk($sformatf("r%0d_written1", n), 32'(wr1), wrm[1]);
      chk($sformatf("r%0d_wovf0", n), 32'(ov0), ovm[0]);
      chk($sformatf("r%0d_wovf1", n), 32'(ov1), ovm[1]);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
